// File: rtl/mpu_stream_pkg.sv
// Shared stream constants and the frame arbiter state encoding.
package mpu_stream_pkg;

    localparam int FRAME_LEN_RS = 255;
    localparam int CONV_OUT_LEN = 512;
    localparam int PARITY_START = 223;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_t;

endpackage

// File: rtl/conv_frame_arbiter_rr_pick.sv
// Combinational round-robin select: first requester after last_grant, wrapping modulo NUM_SRC.
module rr_pick #(
    parameter int NUM_SRC = 2,
    localparam int GW = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [GW-1:0]      last_grant,
    output logic [GW-1:0]      next_grant,
    output logic               any_req
);

    int idx;

    // Scan farthest to nearest so the source closest after last_grant is the one left standing.
    always_comb begin
        next_grant = last_grant;
        any_req    = 1'b0;
        idx        = 0;
        for (int i = NUM_SRC; i >= 1; i--) begin
            idx = (int'(last_grant) + i) % NUM_SRC;
            if (req[idx]) begin
                next_grant = GW'(idx);
                any_req    = 1'b1;
            end else begin
                next_grant = next_grant;
            end
        end
    end

endmodule

// File: rtl/conv_frame_arbiter.sv
// Frame-level round-robin arbiter feeding conv_encoder; locks one source per frame,
// polices length/sop placement and keeps frame and violation statistics.
module conv_frame_arbiter
    import mpu_stream_pkg::*;
#(
    parameter int NUM_SRC   = 2,
    parameter int FRAME_LEN = FRAME_LEN_RS,
    parameter int CNT_W     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [NUM_SRC-1:0]         s_axis_valid,
    output logic [NUM_SRC-1:0]         s_axis_ready,
    input  logic [8*NUM_SRC-1:0]       s_axis_data,
    input  logic [NUM_SRC-1:0]         s_axis_last,
    input  logic [NUM_SRC-1:0]         s_axis_sop,
    input  logic [NUM_SRC-1:0]         s_axis_is_parity,
    output logic                       m_axis_valid,
    input  logic                       m_axis_ready,
    output logic [7:0]                 m_axis_data,
    output logic                       m_axis_last,
    output logic                       m_axis_sop,
    output logic                       m_axis_is_parity,
    output logic [$clog2(NUM_SRC)-1:0] grant_id,
    output logic                       busy,
    output logic                       len_err,
    output logic [CNT_W-1:0]           frames_done,
    output logic [CNT_W-1:0]           err_count
);

    localparam int GW = $clog2(NUM_SRC);
    localparam int BW = $clog2(FRAME_LEN);
    localparam logic [BW-1:0] LAST_BEAT = BW'(FRAME_LEN - 1);

    arb_state_t      state;
    logic [BW-1:0]   beat;
    logic [GW-1:0]   next_id;
    logic            any_req;
    logic            accept;
    logic            viol;

    rr_pick #(.NUM_SRC(NUM_SRC)) u_rr_pick (
        .req        (s_axis_valid),
        .last_grant (grant_id),
        .next_grant (next_id),
        .any_req    (any_req)
    );

    // Zero-latency mux from the locked source; everything is quiet while idle.
    always_comb begin
        m_axis_valid     = 1'b0;
        m_axis_data      = 8'h00;
        m_axis_last      = 1'b0;
        m_axis_sop       = 1'b0;
        m_axis_is_parity = 1'b0;
        s_axis_ready     = '0;
        if (state == ARB_LOCK) begin
            m_axis_valid           = s_axis_valid[grant_id];
            m_axis_data            = s_axis_data[8*int'(grant_id) +: 8];
            m_axis_last            = s_axis_last[grant_id];
            m_axis_sop             = s_axis_sop[grant_id];
            m_axis_is_parity       = s_axis_is_parity[grant_id];
            s_axis_ready[grant_id] = m_axis_ready;
        end else begin
            s_axis_ready = '0;
        end
    end

    // Several coincident violations on one beat still collapse into a single event.
    always_comb begin
        accept = m_axis_valid & m_axis_ready;
        viol   = ((beat == {BW{1'b0}}) & ~m_axis_sop)
               | ((beat != {BW{1'b0}}) &  m_axis_sop)
               | (m_axis_last & (beat != LAST_BEAT))
               | ((beat == LAST_BEAT) & ~m_axis_last);
    end

    // Grant FSM, beat counter and statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ARB_IDLE;
            grant_id    <= GW'(NUM_SRC - 1);
            busy        <= 1'b0;
            len_err     <= 1'b0;
            beat        <= {BW{1'b0}};
            frames_done <= {CNT_W{1'b0}};
            err_count   <= {CNT_W{1'b0}};
        end else begin
            case (state)
                ARB_IDLE: begin
                    len_err <= 1'b0;
                    if (enable && any_req) begin
                        grant_id <= next_id;
                        beat     <= {BW{1'b0}};
                        busy     <= 1'b1;
                        state    <= ARB_LOCK;
                    end
                end
                ARB_LOCK: begin
                    len_err <= accept & viol;
                    if (accept) begin
                        beat <= beat + BW'(1);
                        if (viol && (err_count != {CNT_W{1'b1}})) begin
                            err_count <= err_count + CNT_W'(1);
                        end
                        if (m_axis_last) begin
                            frames_done <= frames_done + CNT_W'(1);
                            busy        <= 1'b0;
                            state       <= ARB_IDLE;
                        end
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    len_err <= 1'b0;
                    state   <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_frame_arbiter.sv
// Directed + random bench for conv_frame_arbiter: per-source scoreboard queues and a cycle model.
module tb_conv_frame_arbiter;
    import mpu_stream_pkg::*;

    localparam int NS = 2;
    localparam int FL = 255;
    localparam int CW = 16;
    localparam int GW = $clog2(NS);

    logic              clk;
    logic              rst;
    logic              enable;
    logic [NS-1:0]     s_axis_valid;
    logic [NS-1:0]     s_axis_ready;
    logic [8*NS-1:0]   s_axis_data;
    logic [NS-1:0]     s_axis_last;
    logic [NS-1:0]     s_axis_sop;
    logic [NS-1:0]     s_axis_is_parity;
    logic              m_axis_valid;
    logic              m_axis_ready;
    logic [7:0]        m_axis_data;
    logic              m_axis_last;
    logic              m_axis_sop;
    logic              m_axis_is_parity;
    logic [GW-1:0]     grant_id;
    logic              busy;
    logic              len_err;
    logic [CW-1:0]     frames_done;
    logic [CW-1:0]     err_count;

    conv_frame_arbiter #(.NUM_SRC(NS), .FRAME_LEN(FL), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .s_axis_valid(s_axis_valid), .s_axis_ready(s_axis_ready), .s_axis_data(s_axis_data),
        .s_axis_last(s_axis_last), .s_axis_sop(s_axis_sop), .s_axis_is_parity(s_axis_is_parity),
        .m_axis_valid(m_axis_valid), .m_axis_ready(m_axis_ready), .m_axis_data(m_axis_data),
        .m_axis_last(m_axis_last), .m_axis_sop(m_axis_sop), .m_axis_is_parity(m_axis_is_parity),
        .grant_id(grant_id), .busy(busy), .len_err(len_err),
        .frames_done(frames_done), .err_count(err_count)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       sop;
        logic       last;
        logic       par;
    } beat_t;

    beat_t src_q[NS][$];
    beat_t exp_q[NS][$];
    logic [GW-1:0] glog[$];

    int compared = 0;
    int mismatched = 0;
    int valid_pct = 100;
    int ready_pct = 100;
    int lerr_seen = 0;
    bit prev_busy = 1'b0;

    bit m_lock;
    int m_gid;
    int m_beat;
    bit m_lerr;
    int m_frames;
    int m_errs;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_lock   = 1'b0;
        m_gid    = NS - 1;
        m_beat   = 0;
        m_lerr   = 1'b0;
        m_frames = 0;
        m_errs   = 0;
    endtask

    task automatic queue_frame(input int src, input int len);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.d    = 8'($urandom);
            b.sop  = (k == 0);
            b.last = (k == len - 1);
            b.par  = (k >= PARITY_START);
            src_q[src].push_back(b);
            exp_q[src].push_back(b);
        end
    endtask

    task automatic drive();
        beat_t b;
        m_axis_ready = ($urandom_range(99) < ready_pct);
        for (int i = 0; i < NS; i++) begin
            if (src_q[i].size() != 0 && $urandom_range(99) < valid_pct) begin
                b = src_q[i][0];
                s_axis_valid[i]      = 1'b1;
                s_axis_data[8*i +: 8] = b.d;
                s_axis_sop[i]        = b.sop;
                s_axis_last[i]       = b.last;
                s_axis_is_parity[i]  = b.par;
            end else begin
                s_axis_valid[i]      = 1'b0;
                s_axis_data[8*i +: 8] = 8'h00;
                s_axis_sop[i]        = 1'b0;
                s_axis_last[i]       = 1'b0;
                s_axis_is_parity[i]  = 1'b0;
            end
        end
    endtask

    task automatic monitor_and_model();
        logic          exp_v, exp_s, exp_l, exp_p;
        logic [7:0]    exp_d;
        logic [NS-1:0] exp_r;
        bit            hs, v, found;
        beat_t         b;
        exp_v = 1'b0; exp_s = 1'b0; exp_l = 1'b0; exp_p = 1'b0;
        exp_d = 8'h00; exp_r = '0;
        if (m_lock) begin
            exp_v = s_axis_valid[m_gid];
            exp_d = s_axis_data[8*m_gid +: 8];
            exp_s = s_axis_sop[m_gid];
            exp_l = s_axis_last[m_gid];
            exp_p = s_axis_is_parity[m_gid];
            exp_r[m_gid] = m_axis_ready;
        end
        chk("m_valid", 32'(m_axis_valid), 32'(exp_v));
        chk("m_data", 32'(m_axis_data), 32'(exp_d));
        chk("m_sop", 32'(m_axis_sop), 32'(exp_s));
        chk("m_last", 32'(m_axis_last), 32'(exp_l));
        chk("m_parity", 32'(m_axis_is_parity), 32'(exp_p));
        chk("s_ready", 32'(s_axis_ready), 32'(exp_r));
        chk("busy", 32'(busy), 32'(m_lock));
        chk("len_err", 32'(len_err), 32'(m_lerr));
        chk("grant_id", 32'(grant_id), 32'(m_gid));
        chk("frames_done", 32'(frames_done), 32'(m_frames));
        chk("err_count", 32'(err_count), 32'(m_errs));
        if (len_err === 1'b1) lerr_seen++;
        if (busy === 1'b1 && !prev_busy) glog.push_back(grant_id);
        prev_busy = (busy === 1'b1);

        hs = exp_v && m_axis_ready;
        if (hs) begin
            chk("sb_nonempty", 32'(exp_q[m_gid].size() != 0), 32'd1);
            if (exp_q[m_gid].size() != 0) begin
                b = exp_q[m_gid].pop_front();
                chk("sb_data", 32'(m_axis_data), 32'(b.d));
                chk("sb_sop", 32'(m_axis_sop), 32'(b.sop));
                chk("sb_last", 32'(m_axis_last), 32'(b.last));
                chk("sb_parity", 32'(m_axis_is_parity), 32'(b.par));
            end
            if (src_q[m_gid].size() != 0) void'(src_q[m_gid].pop_front());
        end

        if (rst) begin
            model_reset();
        end else if (!m_lock) begin
            m_lerr = 1'b0;
            found  = 1'b0;
            if (enable) begin
                for (int k = 1; k <= NS; k++) begin
                    if (!found && s_axis_valid[(m_gid + k) % NS]) begin
                        m_gid = (m_gid + k) % NS;
                        found = 1'b1;
                    end
                end
            end
            if (found) begin
                m_lock = 1'b1;
                m_beat = 0;
            end
        end else begin
            m_lerr = 1'b0;
            if (hs) begin
                v = (m_beat == 0 && !exp_s) || (m_beat != 0 && exp_s) ||
                    (exp_l && m_beat != FL - 1) || (m_beat == FL - 1 && !exp_l);
                if (v) begin
                    m_lerr = 1'b1;
                    if (m_errs != 65535) m_errs++;
                end
                m_beat = (m_beat + 1) % 256;
                if (exp_l) begin
                    m_frames = (m_frames + 1) % 65536;
                    m_lock   = 1'b0;
                end
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor_and_model();
        @(posedge clk);
        #1;
        drive();
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < NS; i++) if (src_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic run_drain(input int maxc);
        int n = 0;
        while (!(all_empty() && !m_lock) && n < maxc) begin
            cycle();
            n++;
        end
        cycle();
        cycle();
        chk("drain_in_budget", 32'(n < maxc), 32'd1);
    endtask

    task automatic run_until_beat(input int bt, input int maxc);
        int n = 0;
        while (!(m_lock && m_beat == bt) && n < maxc) begin
            cycle();
            n++;
        end
        chk("reach_beat_in_budget", 32'(n < maxc), 32'd1);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        enable = 1'b0;
        m_axis_ready = 1'b0;
        s_axis_valid = '0;
        s_axis_data = '0;
        s_axis_sop = '0;
        s_axis_last = '0;
        s_axis_is_parity = '0;
        model_reset();
        cycle();
        cycle();
        rst = 1'b0;
        enable = 1'b1;

        // single source, one clean frame
        queue_frame(0, FL);
        drive();
        run_drain(2000);
        chk("t1_frames", 32'(frames_done), 32'd1);
        chk("t1_no_len_err", 32'(lerr_seen), 32'd0);

        // both sources continuously valid: strict alternation, starting after last grant 0
        glog.delete();
        for (int k = 0; k < 4; k++) begin
            queue_frame(0, FL);
            queue_frame(1, FL);
        end
        drive();
        run_drain(5000);
        chk("t2_grant_count", 32'(glog.size()), 32'd8);
        for (int k = 0; k < 8 && k < glog.size(); k++)
            chk("t2_grant_order", 32'(glog[k]), (k % 2 == 0) ? 32'd1 : 32'd0);
        chk("t2_frames", 32'(frames_done), 32'd9);

        // short frame: last at beat 99
        lerr_seen = 0;
        queue_frame(0, 100);
        queue_frame(0, FL);
        drive();
        run_drain(2000);
        chk("t3_err_count", 32'(err_count), 32'd1);
        chk("t3_len_err_pulses", 32'(lerr_seen), 32'd1);
        chk("t3_frames", 32'(frames_done), 32'd11);

        // enable dropped mid-frame
        queue_frame(0, FL);
        drive();
        run_until_beat(50, 200);
        queue_frame(1, FL);
        enable = 1'b0;
        drive();
        n = 0;
        while (m_lock && n < 1000) begin
            cycle();
            n++;
        end
        chk("t4_frame_done_in_budget", 32'(n < 1000), 32'd1);
        repeat (5) cycle();
        chk("t4_no_grant_disabled", 32'(busy), 32'd0);
        chk("t4_frames", 32'(frames_done), 32'd12);
        enable = 1'b1;
        cycle();
        cycle();
        chk("t4_grant_src1", 32'(grant_id), 32'd1);
        chk("t4_busy_after_enable", 32'(busy), 32'd1);
        run_drain(2000);
        chk("t4_frames_end", 32'(frames_done), 32'd13);

        // random valid/ready traffic
        valid_pct = 70;
        ready_pct = 87;
        for (int k = 0; k < 16; k++) begin
            queue_frame(0, FL);
            queue_frame(1, FL);
        end
        drive();
        run_drain(40000);
        chk("t5_frames", 32'(frames_done), 32'd45);
        chk("t5_err_count", 32'(err_count), 32'd1);
        valid_pct = 100;
        ready_pct = 100;

        // reset in the middle of a locked frame
        queue_frame(1, FL);
        drive();
        run_until_beat(120, 1000);
        rst = 1'b1;
        for (int i = 0; i < NS; i++) begin
            src_q[i].delete();
            exp_q[i].delete();
        end
        drive();
        cycle();
        rst = 1'b0;
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_m_valid", 32'(m_axis_valid), 32'd0);
        chk("t6_m_data", 32'(m_axis_data), 32'd0);
        chk("t6_s_ready", 32'(s_axis_ready), 32'd0);
        chk("t6_frames", 32'(frames_done), 32'd0);
        chk("t6_err_count", 32'(err_count), 32'd0);
        chk("t6_grant_id", 32'(grant_id), 32'(NS - 1));
        chk("t6_len_err", 32'(len_err), 32'd0);
        queue_frame(0, FL);
        queue_frame(1, FL);
        drive();
        cycle();
        cycle();
        chk("t6_first_grant_src0", 32'(grant_id), 32'd0);
        chk("t6_busy_after_grant", 32'(busy), 32'd1);
        run_drain(3000);
        chk("t6_frames_end", 32'(frames_done), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
